// File: rtl/fpdlink_align_ctrl.sv
// FPD-Link word-alignment sequencer: IODELAY2 calibrate/reset, settle, then bitslip until the clock lane word matches.
// Optional FPDLINK_ALIGN_DCB_EN also accepts the DC-balanced clock pattern 7'b1100001.
`timescale 1ns/1ps

module fpdlink_align_lane (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  input  logic i_cal,
  input  logic i_iod_rst,
  output logic o_busy_q,
  output logic o_cal,
  output logic o_iod_rst
);
  // One flop per lane keeps the strobes registered right next to each IODELAY2.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy_q  <= 1'b0;
      o_cal     <= 1'b0;
      o_iod_rst <= 1'b0;
    end else begin
      o_busy_q  <= i_busy;
      o_cal     <= i_cal;
      o_iod_rst <= i_iod_rst;
    end
  end
endmodule

module fpdlink_align_ctrl #(
  parameter int LANES      = 4,
  parameter int RECAL_BITS = 12,
  parameter int MAX_SLIPS  = 14
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic [LANES-1:0] iod_busy,
  input  logic [6:0]       clk_word,
  output logic [LANES-1:0] iod_cal,
  output logic [LANES-1:0] iod_rst,
  output logic             bitslip,
  output logic             aligned,
  output logic [3:0]       slip_count,
  output logic             align_err
);
  localparam int CW = (RECAL_BITS + 1 > 12) ? RECAL_BITS + 1 : 12;

  typedef enum logic [3:0] {
    ST_STARTUP, ST_CAL, ST_WAIT_BUSY, ST_WAIT_IDLE, ST_IOD_RST,
    ST_WAIT_RST, ST_SETTLE, ST_CHECK, ST_SLIP, ST_RUNNING
  } state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_inc;
  logic [LANES-1:0] w_busy_q;
  logic             w_busy_any, w_match, w_recal, w_slip_max, w_err, w_clr;
  logic [3:0]       r_slip;
  logic             r_bitslip, r_aligned, r_err;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      fpdlink_align_lane u_lane (
        .i_clk     (gclk),
        .i_rst     (rst),
        .i_busy    (iod_busy[g]),
        .i_cal     (w_next == ST_CAL),
        .i_iod_rst (w_next == ST_IOD_RST),
        .o_busy_q  (w_busy_q[g]),
        .o_cal     (iod_cal[g]),
        .o_iod_rst (iod_rst[g])
      );
    end
  endgenerate

  assign w_busy_any = |w_busy_q;
  assign w_cnt_inc  = r_cnt + 1'b1;
  // Recalibrate on the edge where the interval bit would set.
  assign w_recal    = w_cnt_inc[RECAL_BITS];
  assign w_slip_max = (r_slip == 4'(MAX_SLIPS));

`ifdef FPDLINK_ALIGN_DCB_EN
  assign w_match = (clk_word == 7'b1100011) || (clk_word == 7'b1100001);
`else
  assign w_match = (clk_word == 7'b1100011);
`endif

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_STARTUP:   if (r_cnt >= CW'(32) && !w_busy_any) w_next = ST_CAL;
      ST_CAL:       w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (w_busy_any) begin
          w_next = ST_WAIT_IDLE;
        end else if (r_cnt == CW'(63)) begin
          w_next = ST_STARTUP;
          w_err  = 1'b1;
        end
      end
      ST_WAIT_IDLE: if (!w_busy_any) w_next = ST_IOD_RST;
      ST_IOD_RST:   w_next = ST_WAIT_RST;
      ST_WAIT_RST:  if (!w_busy_any) w_next = ST_SETTLE;
      ST_SETTLE:    if (r_cnt == CW'(7)) w_next = ST_CHECK;
      ST_CHECK:     w_next = w_match ? ST_RUNNING : ST_SLIP;
      ST_SLIP: begin
        if (w_slip_max) begin
          w_next = ST_STARTUP;
          w_err  = 1'b1;
        end else begin
          w_next = ST_SETTLE;
        end
      end
      ST_RUNNING: begin
        if (w_recal)       w_next = ST_STARTUP;
        else if (!w_match) w_next = ST_SLIP;
      end
      default:      w_next = ST_STARTUP;
    endcase
  end

  // SETTLE->CHECK keeps counting so CHECK sees the settle time elapsed.
  assign w_clr = (w_next != r_state) && !(r_state == ST_SETTLE && w_next == ST_CHECK);

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_STARTUP;
      r_cnt     <= '0;
      r_slip    <= '0;
      r_bitslip <= 1'b0;
      r_aligned <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_clr ? '0 : w_cnt_inc;
      r_bitslip <= (w_next == ST_SLIP) && !w_slip_max;
      r_aligned <= (r_state == ST_RUNNING);
      r_err     <= w_err;
      if (w_next == ST_IOD_RST)
        r_slip <= '0;
      else if (r_state == ST_SLIP && w_next == ST_SETTLE && r_slip != 4'd15)
        r_slip <= r_slip + 4'd1;
    end
  end

  assign bitslip    = r_bitslip;
  assign aligned    = r_aligned;
  assign slip_count = r_slip;
  assign align_err  = r_err;
endmodule

// File: tb/tb_fpdlink_align_ctrl.sv
// Bench for fpdlink_align_ctrl: IODELAY busy responder, bitslip-rotating clock lane, event-time model.
`timescale 1ns/1ps

module tb_fpdlink_align_ctrl;
  localparam int LANES = 4, RB = 6, MAXS = 14;
  localparam logic [6:0] PAT = 7'b1100011;
  localparam logic [6:0] DCB = 7'b1100001;

  logic             gclk, rst;
  logic [LANES-1:0] iod_busy, iod_cal, iod_rst;
  logic [6:0]       clk_word;
  logic             bitslip, aligned, align_err;
  logic [3:0]       slip_count;

  fpdlink_align_ctrl #(.LANES(LANES), .RECAL_BITS(RB), .MAX_SLIPS(MAXS)) dut (
    .gclk(gclk), .rst(rst), .iod_busy(iod_busy), .clk_word(clk_word),
    .iod_cal(iod_cal), .iod_rst(iod_rst), .bitslip(bitslip), .aligned(aligned),
    .slip_count(slip_count), .align_err(align_err)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  int cyc = 0;
  initial forever @(posedge gclk) cyc++;

  // main-owned stimulus knobs
  int         n_checks = 0, n_errors = 0, t0 = 0;
  int         len_cal = 10, len_rst = 10, slip_ref = 0;
  int         b_cal, b_rst, b_slip;
  logic [6:0] word_base = PAT;
  // responder-owned observations
  int         tb_slips = 0, n_cal = 0, n_rst = 0, busy_cnt = 0;
  bit         excl_bad = 1'b0;

  function automatic logic [6:0] rotr7(input logic [6:0] w, input int n);
    logic [6:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[0], r[6:1]};
    return r;
  endfunction

  function automatic logic [6:0] rotl7(input logic [6:0] w, input int n);
    logic [6:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
    return r;
  endfunction

  // ISERDES model: every bitslip rotates the received clock word by one bit.
  assign clk_word = rotr7(word_base, (tb_slips - slip_ref) % 7);

  // IODELAY2 model: BUSY for len_cal / len_rst cycles after CAL / RST.
  initial begin
    iod_busy = '0;
    forever begin
      @(negedge gclk);
      if ((int'(iod_cal[0]) + int'(iod_rst[0]) + int'(bitslip)) > 1 ||
          (iod_cal != '0 && iod_cal != '1) || (iod_rst != '0 && iod_rst != '1))
        excl_bad = 1'b1;
      if (bitslip)    tb_slips++;
      if (iod_cal[0]) n_cal++;
      if (iod_rst[0]) n_rst++;
      if (busy_cnt > 0) busy_cnt--;
      if (iod_cal[0])      busy_cnt = len_cal;
      else if (iod_rst[0]) busy_cnt = len_rst;
      iod_busy = (busy_cnt > 0) ? '1 : '0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return iod_cal[0];
      1:       return iod_rst[0];
      2:       return bitslip;
      3:       return aligned;
      4:       return align_err;
      default: return !aligned;
    endcase
  endfunction

  // Returns the edge number (from reset release) after which the signal was first seen high; -1 on timeout.
  task automatic wait_ev(input int sel, input int limit, output int when);
    when = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge gclk);
      if (sig(sel)) begin
        when = cyc - t0;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [6:0] w, input int lc, input int lr);
    rst = 1'b1;
    len_cal = lc;
    len_rst = lr;
    word_base = w;
    repeat (2) @(negedge gclk);
    slip_ref = tb_slips;
    b_cal = n_cal; b_rst = n_rst; b_slip = tb_slips;
    rst = 1'b0;
    t0 = cyc;
  endtask

  // Timing rules: CAL after 33 edges, WAIT_IDLE sees B busy cycles, SETTLE entry
  // E = 37+B+B2, each SETTLE+CHECK round is 10 edges, RUNNING entry = E+10*slips+9.
  initial begin
    int w, e, er, b, b2, r;
    rst = 1'b1;
    repeat (3) @(negedge gclk);
    chk("reset_outputs", int'({iod_cal, iod_rst, bitslip, aligned, slip_count, align_err}), 0);

    // BUSY never answers: calibration timeout, then fresh startup
    do_reset(PAT, 0, 0);
    wait_ev(0, 100, w); chk("nobusy_cal", w, 33);
    wait_ev(4, 100, w); chk("nobusy_timeout_err", w, 98);
    wait_ev(0, 100, w); chk("nobusy_recal", w, 131);
    chk("nobusy_no_iodrst", n_rst - b_rst, 0);
    chk("nobusy_not_aligned", int'(aligned), 0);

    for (int it = 0; it < 6; it++) begin
      b  = (it < 2) ? 10 : int'($urandom_range(1, 16));
      b2 = (it < 2) ? 10 : int'($urandom_range(0, 16));
      r  = (it == 0) ? 0 : (it == 1) ? 3 : int'($urandom_range(0, 6));
      do_reset(rotl7(PAT, r), b, b2);
      e = 37 + b + b2;
      wait_ev(0, 100, w); chk("cal_edge", w, 33);
      wait_ev(1, 100, w); chk("iodrst_edge", w, 35 + b);
      for (int j = 0; j < r; j++) begin
        wait_ev(2, 100, w); chk("slip_edge", w, e + 9 + 10 * j);
      end
      er = e + 10 * r + 9;
      wait_ev(3, 100, w); chk("aligned_rise", w, er + 1);
      chk("slip_count", int'(slip_count), r);
      chk("cal_pulses", n_cal - b_cal, 1);
      chk("iodrst_pulses", n_rst - b_rst, 1);
      chk("bitslip_pulses", tb_slips - b_slip, r);

      // lose alignment while running: one slip, then realign
      repeat (9) @(negedge gclk);
      slip_ref = tb_slips;
      word_base = rotl7(PAT, 1);
      wait_ev(2, 20, w); chk("run_slip", w, er + 11);
      wait_ev(5, 20, w); chk("run_unalign", w, er + 12);
      wait_ev(3, 40, w); chk("run_realign", w, er + 22);
      chk("run_slip_count", int'(slip_count), r + 1);
      er = er + 21;

      // mismatch in the recalibration cycle: recal wins, no bitslip
      repeat (62) @(negedge gclk);
      slip_ref = tb_slips;
      word_base = ~PAT;
      b_slip = tb_slips;
      wait_ev(5, 20, w); chk("recal_unalign", w, er + 65);
      wait_ev(0, 60, w); chk("recal_cal", w, er + 97);
      chk("recal_no_slip", tb_slips - b_slip, 0);
    end

    // word never matches: MAX_SLIPS slips, then failure
    do_reset(7'b0000000, 10, 10);
    e = 57;
    wait_ev(0, 100, w); chk("zero_cal", w, 33);
    wait_ev(1, 100, w); chk("zero_iodrst", w, 45);
    for (int j = 0; j < MAXS; j++) begin
      wait_ev(2, 30, w); chk("zero_slip_edge", w, e + 9 + 10 * j);
    end
    wait_ev(4, 30, w); chk("zero_err", w, e + 150);
    chk("zero_slip_total", tb_slips - b_slip, MAXS);
    chk("zero_count_held", int'(slip_count), MAXS);
    wait_ev(0, 60, w); chk("zero_recal", w, e + 183);
    chk("zero_count_until_rst", int'(slip_count), MAXS);
    wait_ev(1, 60, w); chk("zero_rst_edge", w, e + 195);
    chk("zero_count_cleared", int'(slip_count), 0);

    // DC-balanced clock pattern
    do_reset(DCB, 10, 10);
`ifdef FPDLINK_ALIGN_DCB_EN
    wait_ev(3, 200, w); chk("dcb_aligned", w, 67);
    chk("dcb_no_slip", tb_slips - b_slip, 0);
`else
    wait_ev(4, 300, w); chk("dcb_err", w, 207);
    chk("dcb_slip_total", tb_slips - b_slip, MAXS);
`endif

    // reset while CAL is high: output drops at once, sequence restarts
    do_reset(rotl7(PAT, 2), 10, 10);
    wait_ev(0, 100, w);
    rst = 1'b1;
    #1 chk("rst_drops_cal", int'(iod_cal), 0);
    do_reset(rotl7(PAT, 2), 10, 10);
    wait_ev(0, 100, w); chk("cal_after_abort", w, 33);
    wait_ev(1, 100, w);
    wait_ev(2, 100, w);
    wait_ev(2, 100, w); chk("second_slip", w, 76);
    rst = 1'b1;
    #1;
    chk("rst_drops_slip", int'(bitslip), 0);
    chk("rst_clears_count", int'(slip_count), 0);
    do_reset(rotl7(PAT, 2), 10, 10);
    wait_ev(0, 100, w); chk("cal_after_slip_abort", w, 33);
    chk("no_slip_after_abort", tb_slips - b_slip, 0);

    chk("strobes_exclusive", int'(excl_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fpdlink_align_ctrl.md
FPDLINK_ALIGN_CTRL -- requirements
Module: fpdlink_align_ctrl

Interface
REQ-001 Parameter LANES, default 4: number of data-lane IODELAY2 pairs sequenced in parallel.
REQ-002 Parameter RECAL_BITS, default 12: periodic recalibration occurs after 2^RECAL_BITS cycles in RUNNING.
REQ-003 Parameter MAX_SLIPS, default 14: number of bitslips allowed per calibration before alignment failure.
REQ-004 Clock and reset (already decided): one clock, `gclk`; reset `rst` is asynchronous and active-high.
REQ-005 gclk  in  1  fabric word clock, 1/7 of the serial bit rate.
REQ-006 rst  in  1  async active-high reset (PLL/BUFPLL not locked).
REQ-007 iod_busy  in  LANES  per-lane IODELAY2 BUSY.
REQ-008 clk_word  in  7  deserialized clock-lane word, bit 6 first-received.
REQ-009 iod_cal  out  LANES  IODELAY2 CAL to every lane, identical bits.
REQ-010 iod_rst  out  LANES  IODELAY2 RST to every lane, identical bits.
REQ-011 bitslip  out  1  ISERDES2 BITSLIP broadcast to clock and data lanes.
REQ-012 aligned  out  1  word alignment valid.
REQ-013 slip_count  out  4  bitslips issued since the last calibration; saturates at 15.
REQ-014 align_err  out  1  one-cycle pulse on alignment failure or calibration timeout.

Function
REQ-015 iod_busy SHALL be registered once (busy_q); every state decision uses busy_any = OR(busy_q).
REQ-016 A free-running 12-bit counter SHALL clear on every state transition except SETTLE→CHECK.
REQ-017 States and transitions:
- STARTUP → CAL when counter ≥ 32 and !busy_any.
- CAL: iod_cal high for exactly 1 cycle → WAIT_BUSY.
- WAIT_BUSY → WAIT_IDLE on busy_any. If counter reaches 63 first → STARTUP with an align_err pulse.
- WAIT_IDLE → IOD_RST on !busy_any.
- IOD_RST: iod_rst high for exactly 1 cycle; clears slip_count → WAIT_RST.
- WAIT_RST → SETTLE on !busy_any.
- SETTLE: wait 8 cycles → CHECK.
- CHECK → RUNNING if clk_word matches a valid pattern; otherwise → SLIP.
- SLIP: bitslip high for exactly 1 cycle; slip_count+1 → SETTLE. If the pre-increment slip_count = MAX_SLIPS, go → STARTUP with an align_err pulse and no bitslip.
- RUNNING → SLIP on pattern mismatch; → STARTUP when counter[RECAL_BITS] sets.
REQ-018 Valid pattern SHALL be 7'b1100011.
REQ-019 aligned SHALL be registered: 1 in the cycle after entering RUNNING; 0 in the cycle after leaving it.
REQ-020 Recalibration expiry and a pattern mismatch in the same cycle: recalibration wins (→ STARTUP, no bitslip).
REQ-021 iod_cal, iod_rst and bitslip SHALL be registered, glitch-free, and never high in the same cycle.
REQ-022 A busy pulse arriving outside WAIT_* states is ignored apart from blocking STARTUP→CAL.

Reset
REQ-023 On rst, the state SHALL go to STARTUP asynchronously and counter, slip_count, busy_q, iod_cal, iod_rst, bitslip, aligned and align_err SHALL go to 0.
REQ-024 Reset asserted mid-sequence (including while iod_cal or bitslip is high) SHALL drop those outputs immediately; no resumption on release.

Configuration
REQ-025 Macro FPDLINK_ALIGN_DCB_EN defined: 7'b1100001 (DC-balanced clock) is also a valid pattern. Undefined: only 7'b1100011 is valid.

Verification
REQ-026 rst release with busy stuck 0: at cycle 33, iod_cal pulses once → after 64 cycles, align_err pulses and the block re-enters STARTUP.
REQ-027 Busy model (high 10 cycles after CAL and after RST) with clk_word = 7'b1100011: exactly one iod_cal and one iod_rst pulse, then aligned=1 and slip_count=0.
REQ-028 clk_word rotated by 3 positions, the model rotating on each bitslip: exactly 3 bitslip pulses, spaced ≥9 cycles apart → aligned=1, slip_count=3.
REQ-029 clk_word held at 7'b0000000: 14 bitslips, then align_err pulse, return to STARTUP, slip_count cleared at the next IOD_RST.
REQ-030 RECAL_BITS=6, aligned: 64 cycles after RUNNING entry, aligned=0 and a new iod_cal pulse follows; a mismatch forced in the expiry cycle produces no bitslip.
REQ-031 clk_word = 7'b1100001: aligned=1 with FPDLINK_ALIGN_DCB_EN; without the macro, continuous slipping until align_err.
